// File: rtl/cam_insert_ctrl.sv
// Request sequencer in front of a CAM: lookup or insert with FIFO replacement.
// Each request is searched once and written only on an insert miss.
module cam_insert_ctrl #(
  parameter int ENTRIES = 32,
  parameter int WIDTH   = 32,
  parameter int IDX_W   = 5
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_op_i,
  input  logic [WIDTH-1:0] req_key_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_hit_o,
  output logic [IDX_W-1:0] rsp_index_o,
  output logic             rsp_evict_o,
  output logic [IDX_W:0]   occupancy_o,
  output logic             cam_search_enable_o,
  output logic [WIDTH-1:0] cam_search_data_o,
  input  logic             cam_search_valid_i,
  input  logic [IDX_W-1:0] cam_search_index_i,
  output logic             cam_write_enable_o,
  output logic [IDX_W-1:0] cam_write_index_o,
  output logic [WIDTH-1:0] cam_write_data_o
);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_WRITE, S_RESP} state_t;

  localparam logic [IDX_W:0]   L_FULL = (IDX_W+1)'(ENTRIES);
  localparam logic [IDX_W-1:0] L_LAST = IDX_W'(ENTRIES - 1);

  state_t           r_state;
  logic             r_op;
  logic [WIDTH-1:0] r_key;
  logic [IDX_W-1:0] r_alloc_ptr;
  logic [IDX_W:0]   r_occ;
  logic             r_req_ready;
  logic             r_search_en;
  logic [WIDTH-1:0] r_search_data;
  logic             r_we;
  logic [IDX_W-1:0] r_widx;
  logic [WIDTH-1:0] r_wdata;
  logic             r_rsp_valid;
  logic             r_hit;
  logic [IDX_W-1:0] r_idx;
  logic             r_evict;
  logic             w_full;

  assign w_full = (r_occ == L_FULL);

  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_state       <= S_IDLE;
      r_op          <= 1'b0;
      r_key         <= '0;
      r_alloc_ptr   <= '0;
      r_occ         <= '0;
      r_req_ready   <= 1'b1;
      r_search_en   <= 1'b0;
      r_search_data <= '0;
      r_we          <= 1'b0;
      r_widx        <= '0;
      r_wdata       <= '0;
      r_rsp_valid   <= 1'b0;
      r_hit         <= 1'b0;
      r_idx         <= '0;
      r_evict       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid_i && r_req_ready) begin
            r_op          <= req_op_i;
            r_key         <= req_key_i;
            r_req_ready   <= 1'b0;
            r_search_en   <= 1'b1;
            r_search_data <= req_key_i;
            r_state       <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          r_search_en   <= 1'b0;
          r_search_data <= '0;
          if (r_op && !cam_search_valid_i) begin
            // Insert miss: claim the oldest slot; evict if every slot is taken.
            r_we    <= 1'b1;
            r_widx  <= r_alloc_ptr;
            r_wdata <= r_key;
            r_hit   <= 1'b0;
            r_idx   <= r_alloc_ptr;
            r_evict <= w_full;
            r_state <= S_WRITE;
          end else begin
            r_hit       <= cam_search_valid_i;
            r_idx       <= cam_search_valid_i ? cam_search_index_i : '0;
            r_evict     <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_WRITE: begin
          r_we        <= 1'b0;
          r_widx      <= '0;
          r_wdata     <= '0;
          r_alloc_ptr <= (r_alloc_ptr == L_LAST) ? '0 : r_alloc_ptr + 1'b1;
          if (!w_full) r_occ <= r_occ + 1'b1;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_hit       <= 1'b0;
            r_idx       <= '0;
            r_evict     <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o         = r_req_ready;
  assign rsp_valid_o         = r_rsp_valid;
  assign rsp_hit_o           = r_hit;
  assign rsp_index_o         = r_idx;
  assign rsp_evict_o         = r_evict;
  assign occupancy_o         = r_occ;
  assign cam_search_enable_o = r_search_en;
  assign cam_search_data_o   = r_search_data;
  assign cam_write_enable_o  = r_we;
  assign cam_write_index_o   = r_widx;
  assign cam_write_data_o    = r_wdata;

endmodule
